// File: rtl/wishbone_master_ctrl_pkg.sv
// Shared definitions for the Wishbone master controller: FSM state encoding
// and the default bus widths also used by the GPIO-side peripherals.
package wishbone_master_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_SEL_W  = 2;

endpackage

// File: rtl/wishbone_master_ctrl_if.sv
// Wishbone classic bus bundle between one initiator and one target.
interface wishbone_master_ctrl_if
  import wishbone_master_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = DEF_SEL_W
) ();

  logic [ADDR_W-1:0] adr_o;
  logic [DATA_W-1:0] dat_o;
  logic [DATA_W-1:0] dat_i;
  logic              we_o;
  logic [SEL_W-1:0]  sel_o;
  logic              cyc_o;
  logic              stb_o;
  logic              ack_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/wishbone_master_ctrl_timeout_cnt.sv
// Bus-cycle watchdog: counts strobe cycles without acknowledge and flags
// the last permitted cycle. A TIMEOUT of 0 disables the flag entirely.
module wishbone_master_ctrl_timeout_cnt #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(TIMEOUT - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit               ENABLED = (TIMEOUT != 0);

  logic [CNT_W-1:0] cnt_r;

  // Wait-cycle counter; saturates so a disabled watchdog never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (srst || clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (en && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  assign expired = ENABLED && (cnt_r == LIMIT);

endmodule

// File: rtl/wishbone_master_ctrl.sv
// Wishbone classic single-cycle initiator. One bus cycle per accepted
// command; the result (read data or timeout flag) is returned on a
// valid/ready response port before the next command is taken.
module wishbone_master_ctrl
  import wishbone_master_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [SEL_W-1:0]      cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  wishbone_master_ctrl_if.master wb
);

  wb_state_e         state_r;
  logic [ADDR_W-1:0] adr_r;
  logic [DATA_W-1:0] dat_r;
  logic              we_r;
  logic [SEL_W-1:0]  sel_r;
  logic              stb_r;
  logic              cmd_ready_r;
  logic              busy_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              cnt_clr_s;
  logic              cnt_en_s;
  logic              expired_s;

  // The watchdog restarts on every accepted command and advances only
  // while the strobe is waiting for an acknowledge.
  assign cnt_clr_s = (state_r == ST_IDLE) && cmd_valid;
  assign cnt_en_s  = (state_r == ST_BUS) && !wb.ack_i;

  wishbone_master_ctrl_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk     (clk),
    .rst     (rst),
    .srst    (srst),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .expired (expired_s)
  );

  // Command/bus/response sequencer with all outputs held in registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      adr_r       <= {ADDR_W{1'b0}};
      dat_r       <= {DATA_W{1'b0}};
      we_r        <= 1'b0;
      sel_r       <= {SEL_W{1'b0}};
      stb_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else if (srst) begin
      state_r     <= ST_IDLE;
      adr_r       <= {ADDR_W{1'b0}};
      dat_r       <= {DATA_W{1'b0}};
      we_r        <= 1'b0;
      sel_r       <= {SEL_W{1'b0}};
      stb_r       <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            adr_r       <= cmd_addr;
            dat_r       <= cmd_wdata;
            we_r        <= cmd_we;
            sel_r       <= cmd_sel;
            stb_r       <= 1'b1;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Acknowledge takes priority over a watchdog expiring in the same cycle.
          if (wb.ack_i) begin
            stb_r       <= 1'b0;
            rsp_rdata_r <= we_r ? {DATA_W{1'b0}} : wb.dat_i;
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end else if (expired_s) begin
            stb_r       <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b1;
            rsp_valid_r <= 1'b1;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            dat_r       <= {DATA_W{1'b0}};
            we_r        <= 1'b0;
            sel_r       <= {SEL_W{1'b0}};
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          stb_r       <= 1'b0;
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign wb.adr_o  = adr_r;
  assign wb.dat_o  = dat_r;
  assign wb.we_o   = we_r;
  assign wb.sel_o  = sel_r;
  assign wb.cyc_o  = stb_r;
  assign wb.stb_o  = stb_r;
  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_wishbone_master_ctrl.sv
// Bench for wishbone_master_ctrl with a programmable stub slave that also
// mirrors a 4-bit LED register at address 0.
module tb_wishbone_master_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        srst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic [1:0]  cmd_sel = 2'b00;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int          checks = 0;
  int          errors = 0;

  // stub slave controls
  int          ack_wait = 0;
  bit          never_ack = 1'b0;
  bit          stray_ack = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  int          stub_cnt = 0;
  logic [3:0]  led;
  logic [31:0] last_rdata = 32'h0;

  wishbone_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(2)) wb_bus ();

  wishbone_master_ctrl #(
    .ADDR_W(32), .DATA_W(32), .SEL_W(2), .TIMEOUT(TIMEOUT), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .srst(srst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .wb(wb_bus)
  );

  always #5 clk = ~clk;

  assign wb_bus.dat_i = slave_rdata;
  assign wb_bus.ack_i = stray_ack | (wb_bus.stb_o & ~never_ack & (stub_cnt == ack_wait));

  always @(posedge clk) begin
    if (!wb_bus.stb_o || wb_bus.ack_i) stub_cnt <= 0;
    else stub_cnt <= stub_cnt + 1;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) led <= 4'h0;
    else if (wb_bus.stb_o && wb_bus.ack_i && wb_bus.we_o && wb_bus.adr_o == 32'h0 && wb_bus.sel_o[0])
      led <= wb_bus.dat_o[3:0];
  end

  // Runs one command and reports what the bus and response port did.
  task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] sel, input int rdelay,
                        output int stb_n, output int lat, output logic [31:0] rdata,
                        output logic err, output int bad_hold);
    int w;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_sel = sel;
    rsp_ready = 1'b0;
    w = 0;
    while (!cmd_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_we = ~we; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_sel = 2'($urandom_range(0, 3));
    stb_n = 0; lat = 1; bad_hold = 0;
    while (!rsp_valid && lat < 100) begin
      if (wb_bus.stb_o) begin
        stb_n++;
        if (wb_bus.adr_o !== addr || wb_bus.we_o !== we || wb_bus.sel_o !== sel ||
            wb_bus.dat_o !== wdata) bad_hold++;
      end
      if (wb_bus.cyc_o !== wb_bus.stb_o) bad_hold++;
      @(negedge clk); lat++;
    end
    if (wb_bus.stb_o !== 1'b0) bad_hold++;
    rdata = rsp_rdata; err = rsp_err;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== rdata || rsp_err !== err || cmd_ready !== 1'b0)
        bad_hold++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || wb_bus.stb_o !== 1'b0 || wb_bus.cyc_o !== 1'b0 || busy !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || wb_bus.adr_o !== 32'h0 || wb_bus.we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rsp_valid=%b stb=%b cyc=%b busy=%b err=%b rdata=%h adr=%h we=%b, required all 0",
               rsp_valid, wb_bus.stb_o, wb_bus.cyc_o, busy, rsp_err, rsp_rdata, wb_bus.adr_o, wb_bus.we_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    int sn, lt, bh; logic [31:0] rd; logic er;
    ack_wait = 0; never_ack = 1'b0;
    do_txn(1'b1, 32'h0, 32'h0000_000A, 2'b11, 0, sn, lt, rd, er, bh);
    checks++;
    if (sn != 1 || lt != 2) begin
      errors++; $display("FAIL write_timing: stb_cycles=%0d latency=%0d required 1/2", sn, lt);
    end
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || bh != 0) begin
      errors++; $display("FAIL write_rsp: rdata=%h err=%b hold_errs=%0d required 0/0/0", rd, er, bh);
    end
    last_rdata = 32'h0;
    checks++;
    if (led !== 4'hA) begin
      errors++; $display("FAIL write_led: got %h required a", led);
    end
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_bus.we_o !== 1'b0 || wb_bus.sel_o !== 2'b00 ||
        wb_bus.dat_o !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL write_return_idle: rsp_valid=%b cmd_ready=%b we=%b sel=%b dat=%h busy=%b required 0/1/0/0/0/0",
               rsp_valid, cmd_ready, wb_bus.we_o, wb_bus.sel_o, wb_bus.dat_o, busy);
    end
  endtask

  task automatic test_read_wait();
    int sn, lt, bh; logic [31:0] rd; logic er;
    ack_wait = 3; never_ack = 1'b0; slave_rdata = 32'hDEAD_BEEF;
    do_txn(1'b0, 32'h0, 32'h1234_5678, 2'b11, 2, sn, lt, rd, er, bh);
    checks++;
    if (sn != 4 || lt != 5 || bh != 0) begin
      errors++; $display("FAIL read_wait_timing: stb=%0d lat=%0d hold_errs=%0d required 4/5/0", sn, lt, bh);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin
      errors++; $display("FAIL read_wait_data: rdata=%h err=%b required deadbeef/0", rd, er);
    end
    last_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_timeout();
    int sn, lt, bh; logic [31:0] rd; logic er;
    never_ack = 1'b1; slave_rdata = 32'hCAFE_0001;
    do_txn(1'b0, 32'h40, 32'h0, 2'b01, 0, sn, lt, rd, er, bh);
    checks++;
    if (sn != TIMEOUT || lt != TIMEOUT + 1 || rd !== 32'h0 || er !== 1'b1 || bh != 0) begin
      errors++;
      $display("FAIL timeout_abort: stb=%0d lat=%0d rdata=%h err=%b hold=%0d required 16/17/0/1/0",
               sn, lt, rd, er, bh);
    end
    never_ack = 1'b0; ack_wait = TIMEOUT - 1; slave_rdata = 32'h5A5A_0F0F;
    do_txn(1'b0, 32'h44, 32'h0, 2'b10, 0, sn, lt, rd, er, bh);
    checks++;
    if (sn != TIMEOUT || lt != TIMEOUT + 1 || rd !== 32'h5A5A_0F0F || er !== 1'b0 || bh != 0) begin
      errors++;
      $display("FAIL timeout_ack_last: stb=%0d lat=%0d rdata=%h err=%b hold=%0d required 16/17/5a5a0f0f/0/0",
               sn, lt, rd, er, bh);
    end
    ack_wait = TIMEOUT;
    do_txn(1'b0, 32'h48, 32'h0, 2'b11, 0, sn, lt, rd, er, bh);
    checks++;
    if (sn != TIMEOUT || rd !== 32'h0 || er !== 1'b1) begin
      errors++; $display("FAIL timeout_ack_late: stb=%0d rdata=%h err=%b required 16/0/1", sn, rd, er);
    end
    last_rdata = 32'h0;
  endtask

  task automatic test_backpressure();
    int bad, w;
    ack_wait = 0; never_ack = 1'b0; slave_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h100; cmd_sel = 2'b11; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_addr = 32'h200; cmd_we = 1'b1; cmd_wdata = 32'h77;
    checks++;
    if (wb_bus.stb_o !== 1'b1 || wb_bus.adr_o !== 32'h100) begin
      errors++; $display("FAIL bp_first_cycle: stb=%b adr=%h required 1/100", wb_bus.stb_o, wb_bus.adr_o);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stray_ack = (i == 2);
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D || rsp_err !== 1'b0 ||
          cmd_ready !== 1'b0 || wb_bus.stb_o !== 1'b0) bad++;
    end
    stray_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wb_bus.stb_o !== 1'b0) begin
      errors++; $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b stb=%b required 0/1/0",
                         rsp_valid, cmd_ready, wb_bus.stb_o);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (wb_bus.stb_o !== 1'b1 || wb_bus.adr_o !== 32'h200 || wb_bus.we_o !== 1'b1) begin
      errors++; $display("FAIL bp_second_start: stb=%b adr=%h we=%b required 1/200/1",
                         wb_bus.stb_o, wb_bus.adr_o, wb_bus.we_o);
    end
    w = 0;
    while (!rsp_valid && w < 50) begin @(negedge clk); w++; end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL bp_second_rsp: valid=%b rdata=%h err=%b required 1/0/0", rsp_valid, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    last_rdata = 32'h0;
  endtask

  task automatic test_reset_mid_bus();
    int stale;
    never_ack = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h8; cmd_sel = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (wb_bus.stb_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: stb=%b required 1", wb_bus.stb_o);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (wb_bus.stb_o !== 1'b0 || wb_bus.cyc_o !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_async: stb=%b cyc=%b rsp_valid=%b busy=%b required 0/0/0/0",
                         wb_bus.stb_o, wb_bus.cyc_o, rsp_valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    never_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_ready: got %b required 1", cmd_ready);
    end
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_bus.stb_o !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL rst_mid_stale: %0d cycles with activity, required 0", stale);
    end
    last_rdata = 32'h0;
  endtask

  task automatic test_soft_reset();
    never_ack = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'hC; cmd_wdata = 32'h3;
    @(negedge clk);
    cmd_valid = 1'b0; srst = 1'b1;
    @(negedge clk);
    srst = 1'b0; never_ack = 1'b0;
    checks++;
    if (wb_bus.stb_o !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL soft_reset: stb=%b cmd_ready=%b rsp_valid=%b busy=%b required 0/1/0/0",
                         wb_bus.stb_o, cmd_ready, rsp_valid, busy);
    end
    last_rdata = 32'h0;
  endtask

  task automatic test_stray_ack();
    int bad;
    bad = 0;
    slave_rdata = $urandom;
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_bus.stb_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 ||
          rsp_rdata !== last_rdata) bad++;
    end
    stray_ack = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stray_ack_idle: %0d disturbed cycles, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    logic [31:0] exp;
    int acc, rsp, bad;
    acc = 0; rsp = 0; bad = 0;
    ack_wait = 0; never_ack = 1'b0; slave_rdata = $urandom;
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cmd_we = 1'($urandom_range(0, 1)); cmd_addr = $urandom; cmd_wdata = $urandom;
      if (cmd_ready) begin
        acc++;
        q.push_back(cmd_we ? 32'h0 : slave_rdata);
      end
      if (rsp_valid) begin
        rsp++;
        if (q.size() == 0) bad++;
        else begin
          exp = q.pop_front();
          if (rsp_rdata !== exp || rsp_err !== 1'b0) bad++;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (acc != 10 || rsp != 10) begin
      errors++; $display("FAIL b2b_throughput: accepted=%0d responses=%0d required 10/10", acc, rsp);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_data: %0d wrong responses, required 0", bad);
    end
    last_rdata = rsp_rdata;
  endtask

  task automatic test_random();
    int sn, lt, bh, exp_stb, bad_n;
    logic [31:0] rd, addr, wdata, exp_rd;
    logic er, we, acked;
    logic [1:0] sel;
    bad_n = 0;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom_range(0, 1)); addr = $urandom; wdata = $urandom;
      sel = 2'($urandom_range(0, 3));
      never_ack = ($urandom_range(0, 4) == 0);
      ack_wait = $urandom_range(0, 20);
      slave_rdata = $urandom;
      acked = !never_ack && (ack_wait < TIMEOUT);
      exp_stb = acked ? ack_wait + 1 : TIMEOUT;
      exp_rd = (acked && !we) ? slave_rdata : 32'h0;
      do_txn(we, addr, wdata, sel, $urandom_range(0, 3), sn, lt, rd, er, bh);
      checks++;
      if (sn != exp_stb || lt != exp_stb + 1 || rd !== exp_rd || er !== !acked || bh != 0) begin
        errors++; bad_n++;
        $display("FAIL random_txn%0d: stb=%0d lat=%0d rdata=%h err=%b hold=%0d required %0d/%0d/%h/%b/0",
                 n, sn, lt, rd, er, bh, exp_stb, exp_stb + 1, exp_rd, !acked);
      end
      last_rdata = exp_rd;
    end
    never_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_backpressure();
    test_stray_ack();
    test_reset_mid_bus();
    test_soft_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
